// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out serializer with a one-word valid/ready holding buffer.
// The serial shifter advances only on bit_en strobes. An empty buffer at a word boundary raises a sticky underrun flag.
module piso_serializer_hs #(
  parameter int   DATA_W    = 10,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              ser_out,
  output logic              frame_start,
  output logic              busy,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              busy_q, busy_d;
  logic              ser_q, ser_d;
  logic              frame_q, frame_d;
  logic              underrun_q, underrun_d;

  logic accept;
  logic last_bit;
  logic load;
  logic underrun_set;

  // Bit that leaves the word first, and the word with that bit consumed.
  function automatic logic pick_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] consume(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign in_ready = rst_n & ~hold_vld_q;
  assign accept   = in_valid & in_ready;
  assign last_bit = busy_q & (bit_cnt_q == LAST_CNT);
  // Loading at the last-bit edge is what keeps back-to-back words gap-free.
  assign load     = bit_en & hold_vld_q & (~busy_q | last_bit);

  always_comb begin
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    busy_d       = busy_q;
    ser_d        = ser_q;
    frame_d      = frame_q;
    underrun_set = 1'b0;

    if (accept) begin
      hold_d     = in_data;
      hold_vld_d = 1'b1;
    end else if (load) begin
      hold_vld_d = 1'b0;
    end

    if (bit_en) begin
      if (load) begin
        ser_d     = pick_bit(hold_q);
        shreg_d   = consume(hold_q);
        bit_cnt_d = '0;
        busy_d    = 1'b1;
        frame_d   = 1'b1;
      end else if (last_bit) begin
        ser_d        = IDLE_BIT;
        bit_cnt_d    = '0;
        busy_d       = 1'b0;
        frame_d      = 1'b0;
        underrun_set = 1'b1;
      end else if (busy_q) begin
        ser_d     = pick_bit(shreg_q);
        shreg_d   = consume(shreg_q);
        bit_cnt_d = bit_cnt_q + 1'b1;
        frame_d   = 1'b0;
      end
    end

    // A new underrun at the same edge as a clear request takes priority.
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      ser_q      <= IDLE_BIT;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      ser_q      <= ser_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  assign ser_out     = ser_q;
  assign frame_start = frame_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Scoreboard bench: accepted words are expanded into expected serial bits in a queue.
// A negedge monitor pops one bit per bit_en edge and compares ser_out and frame_start.
module tb_piso_serializer_hs;

  logic       clk;
  logic       rst_n;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       bit_en;
  logic       ser_out;
  logic       frame_start;
  logic       busy;
  logic       underrun;
  logic       clr_underrun;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_ser;
  logic       m_frame;
  logic       m_busy;
  logic       m_under;

  int tests  = 0;
  int failed = 0;
  int en_mode = 0;
  int en_cnt  = 0;

  piso_serializer_hs #(.DATA_W(10), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_en(bit_en), .ser_out(ser_out), .frame_start(frame_start), .busy(busy),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  piso_serializer_hs #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
    .bit_en(bit_en), .ser_out(m_ser), .frame_start(m_frame), .busy(m_busy),
    .underrun(m_under), .clr_underrun(clr_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-rate strobe: always on, one cycle in four, or random ~2/3 duty.
  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0: bit_en = 1'b1;
        1: begin
          en_cnt = (en_cnt + 1) % 4;
          bit_en = (en_cnt == 0);
        end
        default: bit_en = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Scoreboard entries: {first_bit_of_word, bit_value}
  logic [1:0] exp_q[$];
  logic [1:0] ent;
  logic       s_ok = 1'b0;
  logic       s_rst, s_en, s_acc, s_ser, s_frame, s_busy;
  logic [9:0] s_data;
  int         bits_seen = 0;
  int         ends_seen = 0;

  always @(negedge clk) begin
    if (s_ok) begin
      if (!s_rst) begin
        exp_q.delete();
        check("rst_ser", ser_out, 0);
        check("rst_frame", frame_start, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
      end else begin
        if (s_acc) begin
          for (int i = 0; i < 10; i++) exp_q.push_back({(i == 0), s_data[i]});
        end
        if (s_en) begin
          if (busy) begin
            if (exp_q.size() == 0) begin
              tests++;
              failed++;
              $display("FAIL stale_bit: ser_out=%0b shown while no bit is owed at %0t", ser_out, $time);
            end else begin
              ent = exp_q.pop_front();
              check("ser_bit", ser_out, ent[0]);
              check("frame_start", frame_start, ent[1]);
            end
            bits_seen <= bits_seen + 1;
          end else begin
            check("idle_ser", ser_out, 0);
            check("idle_frame", frame_start, 0);
            if (s_busy) ends_seen <= ends_seen + 1;
          end
        end else begin
          check("frozen_ser", ser_out, s_ser);
          check("frozen_frame", frame_start, s_frame);
          check("frozen_busy", busy, s_busy);
        end
      end
    end
    s_ok    <= 1'b1;
    s_rst   <= rst_n;
    s_en    <= bit_en;
    s_acc   <= in_valid & in_ready;
    s_data  <= in_data;
    s_ser   <= ser_out;
    s_frame <= frame_start;
    s_busy  <= busy;
  end

  task automatic send(input logic [9:0] w);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = w;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 10'($urandom);
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: word %0h not accepted after %0d cycles", w, n);
    end
    check("in_ready_full", in_ready, 0);
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (bits_seen < n && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (bits_seen < n) begin
      tests++;
      failed++;
      $display("FAIL wait_bits: saw %0d bits required %0d", bits_seen, n);
    end
  endtask

  task automatic send_msb(input logic [7:0] w);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    m_valid = 1'b1;
    m_data  = w;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = m_ready;
      @(posedge clk);
      #1;
      n++;
    end
    m_valid = 1'b0;
    check("msb_accept", ok, 1);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("msb_bit", m_ser, w[7-i]);
      check("msb_frame", m_frame, (i == 0));
    end
    @(negedge clk);
    check("msb_idle_ser", m_ser, 1);
    check("msb_busy_end", m_busy, 0);
    check("msb_underrun", m_under, 1);
  endtask

  int         base;
  int         snap;
  int         k;
  logic [9:0] w;

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    clr_underrun = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_busy_out", busy, 0);
    check("rst_under_out", underrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 1);

    // Single LSB-first word, latency and underrun after it
    base = bits_seen;
    send(10'h2B5);
    @(posedge clk);
    #1;
    check("t1_first_frame", frame_start, 1);
    check("t1_first_busy", busy, 1);
    check("t1_first_bit", ser_out, 1);
    wait_bits(base + 10);
    @(posedge clk);
    #1;
    check("t1_end_busy", busy, 0);
    check("t1_end_ser", ser_out, 0);
    check("t1_end_underrun", underrun, 1);

    // Three back-to-back words
    clr_underrun = 1'b1;
    @(posedge clk);
    #1;
    clr_underrun = 1'b0;
    check("t2_cleared", underrun, 0);
    base = bits_seen;
    snap = ends_seen;
    send(10'h3FF);
    send(10'h000);
    send(10'h155);
    wait_bits(base + 30);
    check("t2_no_gap", ends_seen, snap);
    check("t2_underrun_late", underrun, 0);
    check("t2_busy_bit29", busy, 1);
    @(posedge clk);
    #1;
    check("t2_underrun_set", underrun, 1);
    check("t2_busy_end", busy, 0);

    // MSB-first 8-bit instance
    send_msb(8'hA0);
    send_msb(8'($urandom));

    // Slow bit rate: each bit held four cycles
    en_mode = 1;
    base = bits_seen;
    send(10'h2B5);
    w = 10'($urandom);
    send(w);
    wait_bits(base + 20);
    repeat (8) @(posedge clk);
    #1;
    check("t4_drained", busy, 0);
    en_mode = 0;

    // Clear versus set at the same edge, then a lone clear
    base = bits_seen;
    send(10'($urandom));
    wait_bits(base + 10);
    check("t6_pre_underrun", underrun, 1);
    clr_underrun = 1'b1;
    @(posedge clk);
    #1;
    clr_underrun = 1'b0;
    check("t6_set_wins", underrun, 1);
    clr_underrun = 1'b1;
    @(posedge clk);
    #1;
    clr_underrun = 1'b0;
    check("t6_lone_clear", underrun, 0);

    // Reset mid-word with a buffered word
    base = bits_seen;
    send(10'($urandom));
    send(10'($urandom));
    wait_bits(base + 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_ser_idle", ser_out, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ready_back", in_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_stale", busy, 0);

    // Randomized words, gaps and bit_en duty
    en_mode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      send(10'($urandom));
    end
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rand_drain_queue", exp_q.size(), 0);
    check("rand_drain_busy", busy, 0);
    en_mode = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
